// File: rtl/sort_pkg.sv
// Shared types and helpers for the streaming key sorter.
package sort_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Counters must be able to hold DEPTH itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Compare-exchange cell: orders two words by key ascending.
// Optional tie-break on the upper field under SORT_TIEBREAK_EN.
module sort_cmp_swap #(
  parameter int DATA_W = 8,
  parameter int KEY_W  = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi
);

  logic key_gt;
  logic tie_swap;
  logic swap;

  assign key_gt = a[KEY_W-1:0] > b[KEY_W-1:0];

`ifdef SORT_TIEBREAK_EN
  if (KEY_W < DATA_W) begin : g_tie
    // Equal keys: larger upper field goes to the lower index.
    assign tie_swap = (a[KEY_W-1:0] == b[KEY_W-1:0]) &&
                      (a[DATA_W-1:KEY_W] < b[DATA_W-1:KEY_W]);
  end else begin : g_notie
    assign tie_swap = 1'b0;
  end
`else
  assign tie_swap = 1'b0;
`endif

  assign swap = key_gt || tie_swap;
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/stream_key_sorter.sv
// Frame sorter: LOAD DEPTH words, odd-even transposition SORT, DRAIN in order.
// Build option: define SORT_TIEBREAK_EN to break key ties by upper field, descending.
module stream_key_sorter
  import sort_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int KEY_W  = 4,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int CW   = cnt_width(DEPTH);
  localparam int AW   = $clog2(DEPTH);
  localparam int HALF = DEPTH / 2;

  state_t                       state, state_nxt;
  logic [CW-1:0]                cnt, phase;
  logic [DEPTH-1:0][DATA_W-1:0] mem, srt;
  logic [HALF-1:0][DATA_W-1:0]  ca, cb, lo, hi;
  logic                         odd, acc_in, acc_out, cnt_last, phase_last;

  assign odd        = phase[0];
  assign acc_in     = in_valid && (state == LOAD);
  assign acc_out    = out_ready && (state == DRAIN);
  assign cnt_last   = cnt == CW'(DEPTH - 1);
  assign phase_last = phase == CW'(DEPTH - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:    if (acc_in && cnt_last)  state_nxt = SORT;
      SORT:    if (phase_last)          state_nxt = DRAIN;
      DRAIN:   if (acc_out && cnt_last) state_nxt = LOAD;
      default:                          state_nxt = LOAD;
    endcase
    if (abort) state_nxt = LOAD;
  end

  // cnt serves as write pointer in LOAD and read pointer in DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= '0;
    end else if (abort) begin
      cnt   <= '0;
      phase <= '0;
    end else begin
      if (acc_in || acc_out) cnt <= cnt_last ? '0 : cnt + CW'(1);
      if (state == SORT)     phase <= phase_last ? '0 : phase + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (!abort) begin
      if (acc_in)              mem[cnt[AW-1:0]] <= in_data;
      else if (state == SORT)  mem <= srt;
    end
  end

  // Odd phases shift each cell up by one index; the top cell idles.
  for (genvar i = 0; i < HALF; i++) begin : g_cs
    assign ca[i] = odd ? mem[2*i+1] : mem[2*i];
    if (i < HALF - 1) begin : g_mid
      assign cb[i] = odd ? mem[2*i+2] : mem[2*i+1];
    end else begin : g_top
      assign cb[i] = mem[2*i+1];
    end
    sort_cmp_swap #(.DATA_W(DATA_W), .KEY_W(KEY_W)) u_cs (
      .a  (ca[i]),
      .b  (cb[i]),
      .lo (lo[i]),
      .hi (hi[i])
    );
  end

  for (genvar j = 0; j < DEPTH; j++) begin : g_wb
    if (j == 0) begin : g_first
      assign srt[j] = odd ? mem[j] : lo[0];
    end else if (j == DEPTH - 1) begin : g_last
      assign srt[j] = odd ? mem[j] : hi[HALF-1];
    end else if (j % 2 == 1) begin : g_oddj
      assign srt[j] = odd ? lo[(j-1)/2] : hi[(j-1)/2];
    end else begin : g_evenj
      assign srt[j] = odd ? hi[(j-2)/2] : lo[j/2];
    end
  end

  assign in_ready  = state == LOAD;
  assign out_valid = state == DRAIN;
  assign busy      = state != LOAD;
  assign out_data  = out_valid ? mem[cnt[AW-1:0]] : '0;
  assign out_last  = out_valid && cnt_last;

endmodule

// File: doc/stream_key_sorter.md
# stream_key_sorter

Frame-based streaming sorter: accepts a frame of DEPTH words over a valid/ready input, sorts it in place by an odd-even transposition network, then emits the sorted frame over a valid/ready output. Sort key is the low KEY_W bits, ascending; ties are optionally broken by the upper bits, descending. It sits between a packet-field extractor and downstream consumers, and replaces the purely combinational 8-entry sorter with a registered, parametrised, backpressure-aware block.

## Interface
- DATA_W, 8, word width
- KEY_W, 4, key width (low bits of word), 1 ≤ KEY_W ≤ DATA_W
- DEPTH, 8, words per frame, even, ≥ 2
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- abort  input  1  synchronous frame discard
- in_valid  input  1  input word valid
- in_ready  output  1  block accepts input
- in_data  input  DATA_W  input word
- out_valid  output  1  output word valid
- out_ready  input  1  consumer accepts output
- out_data  output  DATA_W  sorted word
- out_last  output  1  marks the final word of the frame
- busy  output  1  high in SORT or DRAIN

One clock; reset is asynchronous and active-high.

## Operation
- Storage: DEPTH×DATA_W register buffer, wr/rd counter, phase counter; all counters $clog2(DEPTH+1) bits wide.
- FSM states: LOAD → SORT → DRAIN → LOAD.
- LOAD: in_ready=1. On in_valid&&in_ready, buf[cnt]=in_data and cnt++. The accept at cnt==DEPTH-1 moves to SORT with cnt=0.
- SORT: one phase per cycle, DEPTH phases in total. Even phase compare-exchanges pairs (0,1),(2,3)… Odd phase compare-exchanges pairs (1,2),(3,4)… Input is ignored and in_ready=0. After phase DEPTH-1, go to DRAIN.
- Swap rule for pair (a,b), a at the lower index: swap if key(a)>key(b). With SORT_TIEBREAK_EN, also swap if the keys are equal and upper(a)<upper(b). Otherwise no swap, so order stays stable.
- DRAIN: out_valid=1, out_data=buf[rd], out_last=(rd==DEPTH-1). On out_valid&&out_ready, rd++. The handshake on the last word returns to LOAD.
- abort: in any state, abort at a clock edge sends the FSM to LOAD and clears all counters. Buffer contents are don't-care. abort beats any handshake in the same cycle: that word is neither stored nor counted as consumed.
- KEY_W==DATA_W: the upper field is empty and ties are never swapped, irrespective of the macro.

## Timing
- All outputs decode from registered state/counters. No combinational path from in_* to out_* or from out_ready to in_ready.
- Reset values: state=LOAD, counters=0, buffer=0. Outputs: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.
- Latency: last input accepted at edge t → SORT runs cycles t+1…t+DEPTH → out_valid is first high in cycle t+DEPTH+1.
- Throughput without backpressure: one frame per 3·DEPTH cycles. There is no overlap between frames.
- out_data/out_last hold stable while out_valid&&!out_ready.
- Reset mid-SORT or mid-DRAIN: immediate return to reset values; a partial frame is never emitted.

## Configuration
- SORT_TIEBREAK_EN defined: keys are equal → larger upper field first.
- SORT_TIEBREAK_EN undefined: keys are equal → input order is preserved (stable). The upper-field comparator is not synthesised.

## Structure
- Package sort_pkg: state enum (LOAD, SORT, DRAIN), and a function that computes the counter width from DEPTH.
- Sub-module sort_cmp_swap: parametrised by DATA_W/KEY_W, two words in → ordered pair out, honours SORT_TIEBREAK_EN. It is instantiated DEPTH/2 times; odd phases reuse these via input muxing.

## Test plan
Defaults DATA_W=8, KEY_W=4, DEPTH=8. The stimulus frame is 13,52,21,40,33,0F,71,02 (hex).
- With the macro, out_ready=1: the stimulus frame → outputs 40,71,21,52,02,33,13,0F, with out_last on 0F and out_valid rising 9 cycles after the last accept.
- Without the macro: the same frame → 40,21,71,52,02,13,33,0F.
- Random out_ready (50%) on the same frame → identical sequence, with out_data stable during every stall and in_ready=0 until the handshake on 0F.
- abort asserted after 5 input words, then a full frame 00…07 → outputs 00..07 only. No stale words appear and busy=0 during LOAD.
- rst pulsed during SORT cycle 3 → all outputs at reset values that cycle. The next frame F0,E1,…,87 (keys 0..7) is emitted unchanged and in order.
- Back-to-back frames with in_valid held high → in_ready=0 throughout SORT/DRAIN. The second frame is accepted starting the cycle after the first frame's out_last handshake.
